// File: rtl/ff_pkg.sv
// Purpose: shared mode encoding and helpers for the configurable flip-flop bank.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: ff_mode_t (D/T/SR/JK encoding), popcount() used by the optional
//           illegal-input counter (FFBANK_ERR_CNT_EN).
package ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_SR = 2'd2,
    MODE_JK = 2'd3
  } ff_mode_t;

  // Widest bank the popcount helper accepts; narrower vectors are zero-extended.
  localparam int unsigned POP_MAX_W = 256;

  function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// Purpose: one channel of next-state logic plus SR illegal-input detect.
// Latency: purely combinational; the owning bank registers the result.
// Backpressure: none; evaluated every cycle, gating by enable is done outside.
// Ports: i_mode  active mode
//        i_q     current state of this channel
//        i_a     D / T / S / J input
//        i_b     R / K input (ignored in D and T)
//        o_q_nxt next state if the channel is enabled
//        o_illegal  high when mode is SR and S=R=1
module ff_cell
  import ff_pkg::*;
(
  input  ff_mode_t i_mode,
  input  logic     i_q,
  input  logic     i_a,
  input  logic     i_b,
  output logic     o_q_nxt,
  output logic     o_illegal
);

  always_comb begin
    o_q_nxt   = i_q;
    o_illegal = 1'b0;
    case (i_mode)
      MODE_D: o_q_nxt = i_a;
      MODE_T: o_q_nxt = i_q ^ i_a;
      MODE_SR: begin
        case ({i_a, i_b})
          2'b01:   o_q_nxt = 1'b0;
          2'b10:   o_q_nxt = 1'b1;
          // S=R=1 is resolved as hold so the state never goes unknown.
          2'b11:   o_illegal = 1'b1;
          default: o_q_nxt = i_q;
        endcase
      end
      MODE_JK: begin
        case ({i_a, i_b})
          2'b01:   o_q_nxt = 1'b0;
          2'b10:   o_q_nxt = 1'b1;
          2'b11:   o_q_nxt = ~i_q;
          default: o_q_nxt = i_q;
        endcase
      end
      default: o_q_nxt = i_q;
    endcase
  end

endmodule

// File: rtl/ff_bank_cfg.sv
// Purpose: WIDTH-channel flip-flop bank with one shared runtime mode (D/T/SR/JK).
// Latency: q, mode and error flags update one clk edge after sampling; qn follows q.
// Backpressure: none; en=0 freezes q and suppresses error detection.
// Ports: clk, rst (sync active-high), en, mode_ld, mode_in, a, b, err_clr ->
//        q, qn, mode, err_sticky, err_pulse; err_cnt only when FFBANK_ERR_CNT_EN
//        is defined (saturating count of illegal SR channel-events).
module ff_bank_cfg
  import ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RST_VAL   = {WIDTH{1'b0}},
  parameter logic [1:0]       RST_MODE  = 2'd3,
  parameter int unsigned      ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode_ld,
  input  logic [1:0]           mode_in,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 err_clr,
`ifdef FFBANK_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qn,
  output logic [1:0]           mode,
  output logic [WIDTH-1:0]     err_sticky,
  output logic                 err_pulse
);

  ff_mode_t         r_mode;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_err_sticky;
  logic             r_err_pulse;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_cell_illegal;
  logic [WIDTH-1:0] w_illegal;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    ff_cell u_cell (
      .i_mode    (r_mode),
      .i_q       (r_q[gi]),
      .i_a       (a[gi]),
      .i_b       (b[gi]),
      .o_q_nxt   (w_q_nxt[gi]),
      .o_illegal (w_cell_illegal[gi])
    );
  end

  // An illegal combination only counts on an edge that actually updates q.
  assign w_illegal = en ? w_cell_illegal : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q          <= RST_VAL;
      r_mode       <= ff_mode_t'(RST_MODE);
      r_err_sticky <= '0;
      r_err_pulse  <= 1'b0;
    end else begin
      // The cells see the old r_mode this edge, so a new mode takes effect next edge.
      if (mode_ld) r_mode <= ff_mode_t'(mode_in);
      if (en)      r_q    <= w_q_nxt;
      // Clear first, then OR in new errors: a fresh error wins over err_clr.
      r_err_sticky <= (err_clr ? '0 : r_err_sticky) | w_illegal;
      r_err_pulse  <= |w_illegal;
    end
  end

`ifdef FFBANK_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic [ERR_CNT_W-1:0] w_cnt_base;
  logic [31:0]          w_cnt_sum;

  // Sum in 32 bits so several simultaneous errors cannot wrap before saturating.
  assign w_cnt_base = err_clr ? '0 : r_err_cnt;
  assign w_cnt_sum  = 32'(w_cnt_base) + popcount(POP_MAX_W'(w_illegal));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_cnt_sum > 32'(CNT_MAX)) begin
      r_err_cnt <= CNT_MAX;
    end else begin
      r_err_cnt <= w_cnt_sum[ERR_CNT_W-1:0];
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign q          = r_q;
  assign qn         = ~r_q;
  assign mode       = r_mode;
  assign err_sticky = r_err_sticky;
  assign err_pulse  = r_err_pulse;

endmodule

// File: tb/tb_ff_bank_cfg.sv
module tb_ff_bank_cfg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned ERR_CNT_W = 4;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic [1:0] mode;
    logic [7:0] st;
    logic       pulse;
    logic [3:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode_ld = 1'b0;
  logic [1:0] mode_in = 2'd0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       err_clr = 1'b0;
  logic [7:0] q, qn, err_sticky;
  logic [1:0] mode;
  logic       err_pulse;
`ifdef FFBANK_ERR_CNT_EN
  logic [3:0] err_cnt;
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;
  bit   stim_done = 1'b0;

  ff_bank_cfg #(
    .WIDTH     (WIDTH),
    .RST_VAL   (8'hA5),
    .RST_MODE  (2'd3),
    .ERR_CNT_W (ERR_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mode_ld    (mode_ld),
    .mode_in    (mode_in),
    .a          (a),
    .b          (b),
    .err_clr    (err_clr),
`ifdef FFBANK_ERR_CNT_EN
    .err_cnt    (err_cnt),
`endif
    .q          (q),
    .qn         (qn),
    .mode       (mode),
    .err_sticky (err_sticky),
    .err_pulse  (err_pulse)
  );

  always #5 clk = ~clk;

  // Drive one edge worth of inputs at the falling edge and queue what the
  // registers must hold after the following rising edge.
  task automatic step(input logic i_rst, input logic i_en, input logic i_ld,
                      input logic [1:0] i_mode, input logic [7:0] i_a,
                      input logic [7:0] i_b, input logic i_clr,
                      input logic [7:0] e_q, input logic [1:0] e_mode,
                      input logic [7:0] e_st, input logic e_pulse,
                      input logic [3:0] e_cnt);
    exp_t e;
    @(negedge clk);
    rst = i_rst; en = i_en; mode_ld = i_ld; mode_in = i_mode;
    a = i_a; b = i_b; err_clr = i_clr;
    step_id++;
    e.id = step_id; e.q = e_q; e.mode = e_mode; e.st = e_st;
    e.pulse = e_pulse; e.cnt = e_cnt;
    sb.push_back(e);
  endtask

  task automatic chk(input int id, input string nm, input logic [7:0] got,
                     input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d %s got=%h want=%h", id, nm, got, want);
    end
  endtask

  // Monitor: after every rising edge, pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.id, "q", q, e.q);
        chk(e.id, "qn", qn, ~e.q);
        chk(e.id, "mode", {6'd0, mode}, {6'd0, e.mode});
        chk(e.id, "err_sticky", err_sticky, e.st);
        chk(e.id, "err_pulse", {7'd0, err_pulse}, {7'd0, e.pulse});
`ifdef FFBANK_ERR_CNT_EN
        chk(e.id, "err_cnt", {4'd0, err_cnt}, {4'd0, e.cnt});
`endif
      end
    end
  end

  initial begin
    //    rst en ld md  a      b      clr  | q      md    st     p  cnt
    // reset, two cycles
    step(1, 0, 0, 0, 8'h00, 8'h00, 0,   8'hA5, 2'd3, 8'h00, 0, 0);
    step(1, 1, 1, 0, 8'hFF, 8'hFF, 0,   8'hA5, 2'd3, 8'h00, 0, 0);
    // JK: clear to 00, then toggle three times
    step(0, 1, 0, 0, 8'h00, 8'hFF, 0,   8'h00, 2'd3, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'hFF, 2'd3, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'h00, 2'd3, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'hFF, 2'd3, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h0F, 8'hF0, 0,   8'h0F, 2'd3, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'hFF, 8'h5A, 0,   8'h0F, 2'd3, 8'h00, 0, 0);
    // load D while en: this edge still JK (0F set by 3C -> 3F)
    step(0, 1, 1, 0, 8'h3C, 8'h00, 0,   8'h3F, 2'd0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h3C, 8'hFF, 0,   8'h3C, 2'd0, 8'h00, 0, 0);
    // load T (edge uses D), then T toggles
    step(0, 1, 1, 1, 8'h3C, 8'h00, 0,   8'h3C, 2'd1, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'hFF, 8'h00, 0,   8'hC3, 2'd1, 8'h00, 0, 0);
    // load SR with en=0: mode still changes, q holds
    step(0, 0, 1, 2, 8'hFF, 8'hFF, 0,   8'hC3, 2'd2, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 8'hFF, 0,   8'h00, 2'd2, 8'h00, 0, 0);
    // SR illegal on bits 7 and 0
    step(0, 1, 0, 0, 8'h81, 8'h81, 0,   8'h00, 2'd2, 8'h81, 1, 2);
    step(0, 1, 0, 0, 8'h01, 8'h00, 0,   8'h01, 2'd2, 8'h81, 0, 2);
    // en=0 with S=R=1: no error
    step(0, 0, 0, 0, 8'hFF, 8'hFF, 0,   8'h01, 2'd2, 8'h81, 0, 2);
    // clear races a new error on bit 1: set wins
    step(0, 1, 0, 0, 8'h02, 8'h02, 1,   8'h01, 2'd2, 8'h02, 1, 1);
    step(0, 1, 0, 0, 8'h00, 8'h00, 1,   8'h01, 2'd2, 8'h00, 0, 0);
    // saturation: 8 + 8 + 8 clamps at 15
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'h01, 2'd2, 8'hFF, 1, 8);
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'h01, 2'd2, 8'hFF, 1, 15);
    step(0, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'h01, 2'd2, 8'hFF, 1, 15);
    // reset mid-sequence, then JK works again
    step(1, 1, 0, 0, 8'hFF, 8'hFF, 0,   8'hA5, 2'd3, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'hFF, 8'h00, 0,   8'hFF, 2'd3, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'h00, 8'h00, 0,   8'hFF, 2'd3, 8'h00, 0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int guard;
    guard = 0;
    wait (stim_done);
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
